hdmi_rx_decoder: RTL and testbench
==================================

# hdmi_rx_decoder

Receive-side counterpart of the HDMI transmit path. It takes three 10-bit TMDS words per pixel clock, already deserialized by the I/O front end, and aligns each channel's word boundary by issuing bitslip requests. It then decodes control and data periods back into 8-bit RGB plus hsync/vsync/de, and regenerates the pixel position and linear frame-buffer address for the downstream buffer writer.

## Interface
- h_pixel, 640, active pixels per line (used for address range checks only)
- v_pixel, 480, active lines per frame
- lock_tokens, 8, consecutive control tokens required to declare a channel aligned
- search_len, 2048, cycles without a qualifying token run before a bitslip is requested
- slip_wait, 4, cycles to hold off after a bitslip pulse

Ports:
- clk_low  input  1  pixel clock; all logic on rising edge
- reset  input  1  reset, synchronous, active-high
- tmds_b, tmds_g, tmds_r  input  10 each  parallel TMDS words (bit 0 first on the wire); channel 0 = blue, 1 = green, 2 = red
- bitslip  output  3  one-cycle pulse per channel (bit 0 = blue); requests a 1-bit word rotation from the deserializer
- locked  output  1  all three channels in LOCKED
- red, green, blue  output  8 each  decoded pixel data; 0 outside de
- hsync, vsync  output  1 each  from blue channel control bits c0 and c1; active-high
- de  output  1  data enable
- pix_x, pix_y  output  11 each  position of the current de pixel
- addr  output  21  linear pixel index within the frame
- frame_start  output  1  one-cycle pulse on vsync rising edge while locked
- de_err  output  1  sticky; set when the channels disagree on control vs data while locked, cleared by reset

## Operation
- Control tokens map to {c1,c0}:
  - 10'b1101010100 → 00
  - 10'b0010101011 → 01
  - 10'b0101010100 → 10
  - 10'b1010101011 → 11
- Any other word is data.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0]
  - out[0] = d[0]
  - for i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1])
- Per-channel alignment FSM, three independent instances:
  - SEARCH: run counter counts consecutive control tokens and clears on any data word; window counter counts cycles.
  - SEARCH → LOCKED when run reaches lock_tokens.
  - SEARCH → SLIP when the window counter reaches search_len-1. That cycle pulses bitslip[ch] and clears both counters.
  - SLIP: waits slip_wait cycles ignoring input, then returns to SEARCH.
  - LOCKED: the window counter restarts each time a run of lock_tokens completes. On reaching search_len-1 without a run: → SEARCH, no slip that cycle.
- Outputs while !locked: de=0, hsync=0, vsync=0, rgb=0, counters held at 0.
- Output rules while locked:
  - de = blue word is data.
  - de_err sets if green or red control/data class differs from blue.
  - hsync/vsync update only on control words and hold their value during data.
- Position and address:
  - On de: pix_x and addr present the current pixel, then increment. pix_x starts at 0.
  - de falling edge: pix_x → 0, pix_y += 1.
  - vsync rising edge: pix_y → 0, addr → 0, frame_start = 1.
- Counter widths: pix_x and pix_y wrap at 2^11; addr wraps at 2^21. No saturation.
- Reset mid-frame: all FSMs go to SEARCH and all counters clear. The first frame_start after relock marks valid data.

## Timing
- Reset values: bitslip=0, locked=0, rgb=0, hsync=0, vsync=0, de=0, pix_x=0, pix_y=0, addr=0, frame_start=0, de_err=0.
- Pipeline latency 2 cycles: input register, then decode/output register. All sideband outputs (de, hsync, vsync, pix_x, pix_y, addr, frame_start) are aligned with rgb.
- locked asserts on the cycle after the last channel enters LOCKED. Loss of lock on any channel drops locked on the next cycle.
- The bitslip pulse is exactly 1 cycle. There is at most one pulse per channel per slip_wait+1 cycles.
- Simultaneous vsync rise and de fall in the same cycle: the vsync reset wins (pix_y=0).

## Test plan
- Aligned 640x480 stream (800x525 totals, hsync/vsync tokens in blanking) from reset → locked after 8 tokens + 1 cycle; bitslip never pulses; de high 640 cycles/line; addr runs 0..307199 and is 0 at frame_start.
- Blue channel rotated by 3 bits → exactly 3 bitslip[0] pulses, each ≥5 cycles apart; then locked=1; green/red bitslip stay 0.
- Data words: 10'h100 → 0x00; 10'h2FF → 0xFE; 10'h3FF → 0x00; each appears on rgb 2 cycles after input.
- Blue token 10'b1010101011 during blanking → hsync=1, vsync=1; following data burst → de=1 with hsync/vsync held at 1.
- Locked stream replaced by constant 10'h100 for 2048 cycles → locked drops, de=0, rgb=0; stream restored → relock, frame_start on next vsync rise.
- Green channel sends a data word while blue sends a control token → de_err=1 and remains set until reset; assert reset mid-line → all outputs 0 the next cycle.

Source files
------------

// File: rtl/hdmi_rx_decoder.sv
// TMDS receive path: per-channel bitslip word alignment, TMDS decode to RGB and
// sync, and pixel position / linear address regeneration for a buffer writer.

module hdmi_rx_lane #(
  parameter int LOCK_TOKENS = 8,
  parameter int SEARCH_LEN  = 2048,
  parameter int SLIP_WAIT   = 4
) (
  input  logic       clk_low,
  input  logic       reset,
  input  logic [9:0] i_q,
  output logic       o_ctl,
  output logic [7:0] o_sym,
  output logic       o_slip,
  output logic       o_locked
);
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  localparam int WW = $clog2(SEARCH_LEN);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {S_SEARCH, S_SLIP, S_LOCKED} state_t;

  state_t        r_state, w_state_n;
  logic [RW-1:0] r_run, w_run_n;
  logic [WW-1:0] r_win, w_win_n;
  logic [SW-1:0] r_wait, w_wait_n;
  logic [1:0]    w_code;
  logic [7:0]    w_d, w_dec;
  logic          w_run_done, w_win_done;

  always_comb begin
    o_ctl  = 1'b1;
    w_code = 2'b00;
    case (i_q)
      10'b1101010100: w_code = 2'b00;
      10'b0010101011: w_code = 2'b01;
      10'b0101010100: w_code = 2'b10;
      10'b1010101011: w_code = 2'b11;
      default:        o_ctl  = 1'b0;
    endcase
  end

  assign w_d = i_q[9] ? ~i_q[7:0] : i_q[7:0];

  always_comb begin
    w_dec    = '0;
    w_dec[0] = w_d[0];
    for (int i = 1; i < 8; i++)
      w_dec[i] = i_q[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
  end

  // Control words carry {c1,c0} in the low bits so the top can share one bus.
  assign o_sym = o_ctl ? {6'd0, w_code} : w_dec;

  assign w_run_done = o_ctl && (r_run == RW'(LOCK_TOKENS - 1));
  assign w_win_done = (r_win == WW'(SEARCH_LEN - 1));

  always_ff @(posedge clk_low) begin
    if (reset) begin
      r_state <= S_SEARCH;
      r_run   <= '0;
      r_win   <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_n;
      r_run   <= w_run_n;
      r_win   <= w_win_n;
      r_wait  <= w_wait_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_run_n   = o_ctl ? r_run + 1'b1 : '0;
    w_win_n   = r_win + 1'b1;
    w_wait_n  = '0;
    o_slip    = 1'b0;
    case (r_state)
      S_SEARCH: begin
        if (w_run_done) begin
          w_state_n = S_LOCKED;
          w_run_n   = '0;
          w_win_n   = '0;
        end else if (w_win_done) begin
          w_state_n = S_SLIP;
          o_slip    = 1'b1;
          w_run_n   = '0;
          w_win_n   = '0;
        end
      end
      S_LOCKED: begin
        if (w_run_done) begin
          w_run_n = '0;
          w_win_n = '0;
        end else if (w_win_done) begin
          w_state_n = S_SEARCH;
          w_run_n   = '0;
          w_win_n   = '0;
        end
      end
      S_SLIP: begin
        // Deserializer output is unsettled right after a slip; ignore it.
        w_run_n  = '0;
        w_win_n  = '0;
        w_wait_n = r_wait + 1'b1;
        if (r_wait == SW'(SLIP_WAIT - 1)) begin
          w_state_n = S_SEARCH;
          w_wait_n  = '0;
        end
      end
      default: w_state_n = S_SEARCH;
    endcase
  end

  assign o_locked = (r_state == S_LOCKED);
endmodule

module hdmi_rx_decoder #(
  parameter int LOCK_TOKENS = 8,
  parameter int SEARCH_LEN  = 2048,
  parameter int SLIP_WAIT   = 4
) (
  input  logic        clk_low,
  input  logic        reset,
  input  logic [9:0]  tmds_b,
  input  logic [9:0]  tmds_g,
  input  logic [9:0]  tmds_r,
  output logic [2:0]  bitslip,
  output logic        locked,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [20:0] addr,
  output logic        frame_start,
  output logic        de_err
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0][9:0] r_q;
  logic [NUM_LANES-1:0][7:0] w_sym;
  logic [NUM_LANES-1:0]      w_ctl, w_lk;
  logic [10:0]               r_x, r_y, w_x_n, w_y_n;
  logic [20:0]               r_a, w_a_n;
  logic                      w_de, w_hs_n, w_vs_n, w_fs, w_err;

  for (genvar ch = 0; ch < NUM_LANES; ch++) begin : g_lane
    hdmi_rx_lane #(
      .LOCK_TOKENS (LOCK_TOKENS),
      .SEARCH_LEN  (SEARCH_LEN),
      .SLIP_WAIT   (SLIP_WAIT)
    ) u_lane (
      .clk_low  (clk_low),
      .reset    (reset),
      .i_q      (r_q[ch]),
      .o_ctl    (w_ctl[ch]),
      .o_sym    (w_sym[ch]),
      .o_slip   (bitslip[ch]),
      .o_locked (w_lk[ch])
    );
  end

  always_comb begin
    w_de   = locked & ~w_ctl[0];
    w_hs_n = 1'b0;
    w_vs_n = 1'b0;
    w_x_n  = '0;
    w_y_n  = '0;
    w_a_n  = '0;
    if (locked) begin
      w_x_n = r_x;
      w_y_n = r_y;
      w_a_n = r_a;
      if (w_ctl[0]) {w_vs_n, w_hs_n} = w_sym[0][1:0];
      else          {w_vs_n, w_hs_n} = {vsync, hsync};
      if (w_de) begin
        w_x_n = r_x + 11'd1;
        w_a_n = r_a + 21'd1;
      end else if (de) begin
        w_x_n = '0;
        w_y_n = r_y + 11'd1;
      end
      // A vsync rise on the same word that ends de still restarts the frame.
      if (w_vs_n && !vsync) begin
        w_y_n = '0;
        w_a_n = '0;
      end
    end
    w_fs  = w_vs_n & ~vsync;
    w_err = locked & ((w_ctl[1] ^ w_ctl[0]) | (w_ctl[2] ^ w_ctl[0]));
  end

  always_ff @(posedge clk_low) begin
    if (reset) begin
      r_q         <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_a         <= '0;
      locked      <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      addr        <= '0;
      frame_start <= 1'b0;
      de_err      <= 1'b0;
    end else begin
      r_q         <= {tmds_r, tmds_g, tmds_b};
      r_x         <= w_x_n;
      r_y         <= w_y_n;
      r_a         <= w_a_n;
      locked      <= &w_lk;
      red         <= w_de ? w_sym[2] : 8'd0;
      green       <= w_de ? w_sym[1] : 8'd0;
      blue        <= w_de ? w_sym[0] : 8'd0;
      hsync       <= w_hs_n;
      vsync       <= w_vs_n;
      de          <= w_de;
      pix_x       <= w_de ? r_x : w_x_n;
      pix_y       <= w_de ? r_y : w_y_n;
      addr        <= w_de ? r_a : w_a_n;
      frame_start <= w_fs;
      if (w_err) de_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hdmi_rx_decoder.sv
// Scoreboard bench for hdmi_rx_decoder: random TMDS-encoded pixels, a
// deserializer model that honours bitslip, and a decoupled output monitor.

module tb_hdmi_rx_decoder;
  localparam int H_ACT = 16, H_TOT = 28, V_ACT = 4, V_TOT = 8;
  localparam logic [9:0] TOK [4] = '{10'b1101010100, 10'b0010101011,
                                     10'b0101010100, 10'b1010101011};
  localparam logic [9:0] DW [3] = '{10'h100, 10'h2FF, 10'h3FF};
  localparam logic [7:0] DX [3] = '{8'h00, 8'hFE, 8'h00};

  logic        clk_low = 1'b0;
  logic        reset;
  logic [9:0]  tmds_b, tmds_g, tmds_r;
  logic [2:0]  bitslip;
  logic        locked, hsync, vsync, de, frame_start, de_err;
  logic [7:0]  red, green, blue;
  logic [10:0] pix_x, pix_y;
  logic [20:0] addr;

  hdmi_rx_decoder dut (
    .clk_low(clk_low), .reset(reset),
    .tmds_b(tmds_b), .tmds_g(tmds_g), .tmds_r(tmds_r),
    .bitslip(bitslip), .locked(locked),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_x(pix_x), .pix_y(pix_y), .addr(addr),
    .frame_start(frame_start), .de_err(de_err)
  );

  always #5 clk_low = ~clk_low;

  typedef struct {
    logic [23:0] rgb;
    logic [10:0] x, y;
    logic [20:0] a;
    logic [1:0]  sync;
    int          cyc;
  } pix_t;

  pix_t pq[$];
  int   fsq[$];
  int   checks = 0, errors = 0, cyc = 0;
  bit   sb_on = 0;
  int   rot[3], slips[3], last_slip[3];
  bit   m_hs, m_vs, m_de;
  int   m_x, m_y, m_a;

  always @(posedge clk_low) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int tok_idx(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == TOK[k]) return k;
    return -1;
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [19:0] d;
    d = {w, w};
    return d[19-r -: 10];
  endfunction

  // Transition-minimising encode with random q8/q9 choices; never lands on a token.
  function automatic logic [9:0] enc(input logic [7:0] v);
    logic [7:0] d;
    logic       q8, q9;
    logic [9:0] w;
    do begin
      q8   = 1'($urandom_range(0, 1));
      q9   = 1'($urandom_range(0, 1));
      d[0] = v[0];
      for (int i = 1; i < 8; i++) d[i] = q8 ? (d[i-1] ^ v[i]) : ~(d[i-1] ^ v[i]);
      w = {q9, q8, q9 ? ~d : d};
    end while (tok_idx(w) >= 0);
    return w;
  endfunction

  task automatic model_reset();
    m_hs = 0; m_vs = 0; m_de = 0; m_x = 0; m_y = 0; m_a = 0;
  endtask

  // Reference: every data symbol is one pixel in raster order of the frame.
  task automatic model(input logic [9:0] b, input logic [23:0] rgb);
    int   k;
    pix_t p;
    k = tok_idx(b);
    if (k >= 0) begin
      if (m_de) begin m_x = 0; m_y++; end
      if (k[1] && !m_vs) begin m_y = 0; m_a = 0; fsq.push_back(cyc); end
      m_vs = k[1]; m_hs = k[0]; m_de = 0;
    end else begin
      p.rgb = rgb; p.x = 11'(m_x); p.y = 11'(m_y); p.a = 21'(m_a);
      p.sync = {m_vs, m_hs}; p.cyc = cyc;
      pq.push_back(p);
      m_x++; m_a++; m_de = 1;
    end
  endtask

  task automatic drive(input logic [9:0] b, g, r, input logic [23:0] exp_rgb);
    @(negedge clk_low);
    for (int c = 0; c < 3; c++) if (bitslip[c]) begin
      if (slips[c] > 0) chk("slip_spacing_ge5", 64'((cyc - last_slip[c]) >= 5), 1);
      slips[c]++;
      last_slip[c] = cyc;
      rot[c] = (rot[c] == 0) ? 9 : rot[c] - 1;
    end
    tmds_b = rotl(b, rot[0]);
    tmds_g = rotl(g, rot[1]);
    tmds_r = rotl(r, rot[2]);
    if (sb_on) model(b, exp_rgb);
  endtask

  task automatic blank(input int n, input int k);
    for (int i = 0; i < n; i++) drive(TOK[k], TOK[k], TOK[k], '0);
  endtask

  task automatic send_pix();
    logic [7:0] vb, vg, vr;
    vb = 8'($urandom); vg = 8'($urandom); vr = 8'($urandom);
    drive(enc(vb), enc(vg), enc(vr), {vr, vg, vb});
  endtask

  task automatic send_frame(input bit directed);
    for (int l = 0; l < V_TOT; l++)
      for (int c = 0; c < H_TOT; c++) begin
        if (l < V_ACT && c < H_ACT) begin
          if (directed && l == 0 && c < 3) drive(DW[c], DW[c], DW[c], {3{DX[c]}});
          else send_pix();
        end else begin
          int k;
          k = ((l >= 5 && l < 7) ? 2 : 0) + ((c >= 20 && c < 24) ? 1 : 0);
          drive(TOK[k], TOK[k], TOK[k], '0);
        end
      end
  endtask

  task automatic wait_lock(input string name, input int max, output int n);
    n = 0;
    while (!locked && n < max) begin blank(1, 0); n++; end
    chk(name, locked, 1);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_locked"}, locked, 0);
    chk({t, "_rgb"}, {red, green, blue}, 0);
    chk({t, "_sync_de"}, {hsync, vsync, de}, 0);
    chk({t, "_pos"}, {pix_x, pix_y, addr}, 0);
    chk({t, "_fs_err_slip"}, {frame_start, de_err, bitslip}, 0);
  endtask

  // Monitor: pops the model queues whenever the DUT presents a pixel or frame start.
  always @(negedge clk_low) if (sb_on) begin
    pix_t p;
    int   fc;
    if (de) begin
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL pix_unexpected: got de=1 at x=%0d expected no pixel", pix_x);
      end else begin
        p = pq.pop_front();
        chk("pix_rgb", {red, green, blue}, p.rgb);
        chk("pix_x", pix_x, p.x);
        chk("pix_y", pix_y, p.y);
        chk("pix_addr", addr, p.a);
        chk("pix_vs_hs", {vsync, hsync}, p.sync);
        chk("pix_latency", cyc, p.cyc + 2);
      end
    end
    if (frame_start) begin
      if (fsq.size() == 0) begin
        checks++; errors++;
        $display("FAIL fs_unexpected: got frame_start=1 expected 0");
      end else begin
        fc = fsq.pop_front();
        chk("fs_latency", cyc, fc + 2);
        chk("fs_y_addr", {pix_y, addr}, 0);
      end
    end
  end

  initial begin
    int n;
    reset = 1;
    tmds_b = TOK[0]; tmds_g = TOK[0]; tmds_r = TOK[0];
    for (int c = 0; c < 3; c++) begin rot[c] = 0; slips[c] = 0; last_slip[c] = 0; end
    model_reset();
    repeat (3) @(negedge clk_low);
    chk_zero("reset");
    reset = 0;

    wait_lock("lock_aligned", 50, n);
    chk("lock_latency", n, 10);
    model_reset();
    sb_on = 1;
    send_frame(1);
    send_frame(0);
    send_frame(0);
    blank(10, 0);

    // Both syncs high, then a data burst keeps them held.
    blank(10, 3);
    for (int i = 0; i < 5; i++) send_pix();
    blank(10, 0);
    chk("de_err_clear", de_err, 0);

    drive(TOK[0], 10'h100, TOK[0], '0);
    blank(3, 0);
    chk("de_err_set", de_err, 1);
    blank(20, 0);
    chk("de_err_sticky", de_err, 1);

    sb_on = 0;
    for (int i = 0; i < 2060; i++) drive(10'h100, 10'h100, 10'h100, '0);
    chk("loss_locked", locked, 0);
    chk("loss_de", de, 0);
    chk("loss_rgb", {red, green, blue}, 0);
    chk("de_err_kept", de_err, 1);
    wait_lock("relock", 50, n);
    model_reset();
    sb_on = 1;
    send_frame(0);
    send_frame(0);
    blank(5, 0);
    chk("pix_queue_empty", pq.size(), 0);
    chk("fs_queue_empty", fsq.size(), 0);

    sb_on = 0;
    blank(H_TOT, 0);
    for (int i = 0; i < 6; i++) send_pix();
    reset = 1;
    @(negedge clk_low);
    chk_zero("midline_reset");
    reset = 0;

    rot[0] = 3;
    wait_lock("lock_rotated", 8000, n);
    chk("slips_blue", slips[0], 3);
    chk("slips_green", slips[1], 0);
    chk("slips_red", slips[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
